// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_write_arbiter_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input reg_addr_t rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for port B writeback results; exposes per-entry valid/rd for the pending mask.
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  reg_addr_t        push_rd_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output reg_addr_t        head_rd_o,
  output logic [Width-1:0] head_data_o,
  output logic [Depth-1:0] entry_valid_o,
  output reg_addr_t        entry_rd_o [Depth]
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Depth-1:0]   valid_q, valid_d;
  reg_addr_t          rd_q   [Depth];
  logic [Width-1:0]   data_q [Depth];
  logic               do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_rd_o     = rd_q[rd_ptr_q[PtrW-1:0]];
  assign head_data_o   = data_q[rd_ptr_q[PtrW-1:0]];
  assign entry_valid_o = valid_q;
  assign entry_rd_o    = rd_q;

  always_comb begin
    valid_d = valid_q;
    if (do_pop)  valid_d[rd_ptr_q[PtrW-1:0]] = 1'b0;
    if (do_push) valid_d[wr_ptr_q[PtrW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      rd_q[wr_ptr_q[PtrW-1:0]]   <= push_rd_i;
      data_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (A) and a buffered
// multi-cycle unit (B), with a starvation guard that forces B after repeated denial.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [4:0]          a_rd,
  input  logic [XLEN-1:0]     a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [4:0]          b_rd,
  input  logic [XLEN-1:0]     b_data,
  output logic                RegWrite,
  output logic [4:0]          WriteReg,
  output logic [XLEN-1:0]     WriteData,
  output logic [NUM_REGS-1:0] pending_mask
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic               full, empty, push, pop, force_b, a_write;
  reg_addr_t          head_rd;
  logic [XLEN-1:0]    head_data;
  logic [DEPTH-1:0]   entry_valid;
  reg_addr_t          entry_rd [DEPTH];

  logic [StarveW-1:0] starve_q, starve_d;
  logic               regwrite_q, regwrite_d;
  reg_addr_t          writereg_q, writereg_d;
  logic [XLEN-1:0]    writedata_q, writedata_d;

  wb_fifo #(
    .Depth (DEPTH),
    .Width (XLEN)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .push_rd_i     (b_rd),
    .push_data_i   (b_data),
    .pop_i         (pop),
    .full_o        (full),
    .empty_o       (empty),
    .head_rd_o     (head_rd),
    .head_data_o   (head_data),
    .entry_valid_o (entry_valid),
    .entry_rd_o    (entry_rd)
  );

  assign force_b = !empty && (starve_q == StarveMax);
  assign a_ready = !force_b && !rst;
  assign b_ready = !full && !rst;
  // A b_rd of zero completes the handshake but is never queued.
  assign push    = b_valid && b_ready && (b_rd != '0);
  assign pop     = !rst && !empty && (force_b || !a_valid);
  assign a_write = a_valid && a_ready && (a_rd != '0);

  always_comb begin
    starve_d = starve_q;
    if (empty || pop)             starve_d = '0;
    else if (starve_q != StarveMax) starve_d = starve_q + StarveW'(1);
  end

  always_comb begin
    regwrite_d  = pop || a_write;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (pop) begin
      writereg_d  = head_rd;
      writedata_d = head_data;
    end else if (a_write) begin
      writereg_d  = a_rd;
      writedata_d = a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entry_valid[i]) pending_mask = pending_mask | rd_onehot(entry_rd[i]);
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = writereg_q;
  assign WriteData = writedata_q;

endmodule
